// File: rtl/rca_pipe_adder.sv
// rca_pipe_adder
//   Pipelined ripple-carry adder/subtractor. A WIDTH-bit operation is split
//   into STAGES = WIDTH/SEG ripple segments, one per pipeline stage, with the
//   segment carry registered between stages. Operands ride along the pipe so
//   each stage sees its own segment, and the finished low sum segments travel
//   forward so the whole result leaves the last stage aligned.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake (in_ready = pipe advances this cycle)
//   a, b, cin, sub      operands; sub=1 gives a-b (cin ignored)
//   out_valid/out_ready output handshake
//   sum, cout, ovf      result mod 2^WIDTH, MSB carry-out, signed overflow
module rca_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SEG_SAFE = (SEG < 1) ? 1 : SEG;
    localparam int STAGES   = (WIDTH / SEG_SAFE < 1) ? 1 : (WIDTH / SEG_SAFE);

    if (SEG < 1 || (WIDTH % SEG_SAFE) != 0) begin : g_bad_param
        $error("rca_pipe_adder: WIDTH must be a positive multiple of SEG");
    end

    // Per-stage registers; index STAGES-1 is the output stage.
    logic [WIDTH-1:0] pa [STAGES];
    logic [WIDTH-1:0] pb [STAGES];
    logic [WIDTH-1:0] ps [STAGES];
    logic             pc [STAGES];
    logic             pv [STAGES];
    logic             ovf_q;

    // Next-state values for every stage.
    logic [WIDTH-1:0] na [STAGES];
    logic [WIDTH-1:0] nb [STAGES];
    logic [WIDTH-1:0] ns [STAGES];
    logic             nc [STAGES];
    logic             nv [STAGES];
    logic             n_ovf;
    logic             adv;

    // Working values for the stage currently being evaluated.
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] ss;
    logic             sc;
    logic             sv;
    logic [SEG_SAFE:0] t;

    always_comb begin
        adv   = out_ready || !pv[STAGES-1];
        n_ovf = 1'b0;
        sa    = '0;
        sb    = '0;
        ss    = '0;
        sc    = 1'b0;
        sv    = 1'b0;
        t     = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                sa = a;
                sb = b ^ {WIDTH{sub}};
                ss = '0;
                sc = sub | cin;
                sv = in_valid;
            end else begin
                sa = pa[k-1];
                sb = pb[k-1];
                ss = ps[k-1];
                sc = pc[k-1];
                sv = pv[k-1];
            end
            t = {1'b0, sa[k*SEG_SAFE +: SEG_SAFE]}
              + {1'b0, sb[k*SEG_SAFE +: SEG_SAFE]}
              + {{SEG_SAFE{1'b0}}, sc};
            na[k] = sa;
            nb[k] = sb;
            ns[k] = ss;
            ns[k][k*SEG_SAFE +: SEG_SAFE] = t[SEG_SAFE-1:0];
            nc[k] = t[SEG_SAFE];
            nv[k] = sv;
            // Carry into the MSB is recovered from the MSB sum bit
            // (s = a ^ b ^ c), which also covers SEG = 1.
            if (k == STAGES - 1) begin
                n_ovf = (sa[WIDTH-1] ^ sb[WIDTH-1] ^ t[SEG_SAFE-1]) ^ t[SEG_SAFE];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                pa[k] <= '0;
                pb[k] <= '0;
                ps[k] <= '0;
                pc[k] <= 1'b0;
                pv[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (adv) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                pv[k] <= nv[k];
                // The output stage only reloads data for a valid result so
                // sum/cout/ovf never change on a bubble.
                if (k != STAGES - 1 || nv[k]) begin
                    pa[k] <= na[k];
                    pb[k] <= nb[k];
                    ps[k] <= ns[k];
                    pc[k] <= nc[k];
                end
            end
            if (nv[STAGES-1]) begin
                ovf_q <= n_ovf;
            end
        end
    end

    assign in_ready  = adv;
    assign out_valid = pv[STAGES-1];
    assign sum       = ps[STAGES-1];
    assign cout      = pc[STAGES-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_rca_pipe_adder.sv
// tb_rca_pipe_adder
//   Scoreboard bench for rca_pipe_adder (WIDTH=16, SEG=4). Accepted operations
//   push their expected result (from plain integer arithmetic) into a queue;
//   an independent monitor pops and compares on every output handshake and
//   also checks output stability while the consumer stalls.
module tb_rca_pipe_adder;

    localparam int W      = 16;
    localparam int SEG    = 4;
    localparam int STAGES = W / SEG;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    rca_pipe_adder #(.WIDTH(W), .SEG(SEG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           cyc;
    } exp_t;

    exp_t   sb_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    int     cyc   = 0;
    bit     lat_chk = 0;
    bit     gen_done = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                   input logic ic, input logic is);
        exp_t         e;
        logic [W-1:0] bp;
        logic [W:0]   full;
        bp     = is ? ~ib : ib;
        full   = {1'b0, ia} + {1'b0, bp} + (W+1)'(is ? 1'b1 : ic);
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (ia[W-1] == bp[W-1]) && (e.sum[W-1] != ia[W-1]);
        e.cyc  = 0;
        return e;
    endfunction

    // Present one op from a falling edge until it is accepted.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ic, input logic is, input bit first_ready);
        int   tries = 0;
        bit   done  = 0;
        exp_t e;
        while (!done) begin
            @(negedge clk);
            a = ia; b = ib; cin = ic; sub = is; in_valid = 1'b1;
            #4;
            if (first_ready && tries == 0) chk("in_ready_stream", in_ready, 1);
            if (in_ready) begin
                e     = model(ia, ib, ic, is);
                e.cyc = cyc;
                sb_q.push_back(e);
                done  = 1;
            end
            tries++;
            if (!done && tries > 1000) begin
                n_cmp++; n_bad++;
                $display("FAIL accept_timeout: in_ready stuck at %0b, expected 1", in_ready);
                done = 1;
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (sb_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: %0d results pending, expected 0", sb_q.size());
        end
    endtask

    // Monitor
    logic [W-1:0] h_sum;
    logic         h_cout;
    logic         h_ovf;
    bit           held = 0;
    exp_t         me;

    always begin
        @(negedge clk);
        #3;
        if (!rst_n) begin
            held = 0;
        end else begin
            if (held) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_sum", sum, h_sum);
                chk("hold_cout", cout, h_cout);
                chk("hold_ovf", ovf, h_ovf);
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_result: got sum %0h, expected no result", sum);
                end else begin
                    me = sb_q.pop_front();
                    chk("sum", sum, me.sum);
                    chk("cout", cout, me.cout);
                    chk("ovf", ovf, me.ovf);
                    if (lat_chk) chk("latency", cyc - me.cyc, STAGES);
                end
            end
            held   = out_valid && !out_ready;
            h_sum  = sum;
            h_cout = cout;
            h_ovf  = ovf;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Wrap-around carry, single-cycle output pulse.
        out_ready = 1'b1; lat_chk = 1;
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        drain(50);
        #3 chk("single_pulse", out_valid, 0);

        // Signed overflow, then subtraction with borrow.
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        issue(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
        drain(50);

        // Back-to-back stream.
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] iv;
            iv = W'(i);
            issue(iv, W'(16'h1000 * i), iv[0], 1'b0, 1);
        end
        drain(50);

        // Fill, stall three cycles, resume.
        lat_chk = 0;
        for (int i = 0; i < 4; i++) issue(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            out_ready = 1'b0;
            #4 chk("stall_in_ready", in_ready, 0);
        end
        @(negedge clk); out_ready = 1'b1;
        drain(50);

        // Asynchronous reset mid-cycle with ops in flight.
        out_ready = 1'b0;
        issue(16'h1234, 16'h4321, 1'b1, 1'b0, 0);
        issue(16'hAAAA, 16'h5555, 1'b0, 1'b1, 0);
        issue(16'h8000, 16'h8000, 1'b0, 1'b0, 0);
        issue(16'h0F0F, 16'h0101, 1'b1, 1'b0, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_sum", sum, 0);
        chk("async_rst_cout", cout, 0);
        chk("async_rst_ovf", ovf, 0);
        sb_q.delete();
        @(negedge clk); #1 rst_n = 1'b1;
        out_ready = 1'b1; lat_chk = 1;
        issue(16'h00FF, 16'h0F01, 1'b0, 1'b0, 0);
        drain(50);
        repeat (6) @(negedge clk);

        // Random traffic with random consumer back-pressure.
        lat_chk = 0;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    if ($urandom_range(3) == 0) @(negedge clk);
                    issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 0);
                end
                gen_done = 1;
            end
            begin
                int n = 0;
                while ((!gen_done || sb_q.size() != 0) && n < 80000) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(3) != 0);
                    n++;
                end
                if (!gen_done || sb_q.size() != 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL random_timeout: %0d results pending, expected 0", sb_q.size());
                end
                out_ready = 1'b1;
            end
        join

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
